// File: rtl/tdm_demux_pkg.sv
// Shared constants and state type for the 1:4 TDM demultiplexer.
package tdm_demux_pkg;
   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter: load-to-1 on sync, increment per sample,
// terminal flag on the last slot of a frame.
module tdm_slot_counter
   import tdm_demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot,
   output logic              last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         slot <= '0;
      else if (load)
         slot <= SLOT_W'(1);
      else if (inc)
         slot <= slot + SLOT_W'(1);
   end

   assign last = inc && (slot == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1:4 TDM demultiplexer with frame-sync alignment.
// Optional sticky misalignment flag: TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux_1to4
   import tdm_demux_pkg::*;
#(
   parameter int W = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [W-1:0]        in_data,
   input  logic                in_sync,
   input  logic                err_clr,
   output logic [NUM_CH*W-1:0] out_frame,
   output logic                out_valid,
   output logic [SLOT_W-1:0]   slot,
   output logic                locked,
   output logic                sync_err
);

   state_t     state;
   state_t     state_nxt;
   logic       load;
   logic       inc;
   logic       last;
   logic [W-1:0] ch [NUM_CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= HUNT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (in_valid && in_sync)
         state_nxt = LOCKED;
   end

   // A sync always restarts at slot 0; plain samples only count once locked.
   always_comb begin
      locked = (state == LOCKED);
      load   = in_valid && in_sync;
      inc    = in_valid && !in_sync && (state == LOCKED);
   end

   tdm_slot_counter u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .inc  (inc),
      .slot (slot),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            ch[i] <= '0;
         out_frame <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= last;
         if (load)
            ch[0] <= in_data;
         else if (inc)
            ch[slot] <= in_data;
         if (last)
            out_frame <= {in_data, ch[2], ch[1], ch[0]};
      end
   end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
   logic misalign;
   assign misalign = load && (state == LOCKED) && (slot != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sync_err <= 1'b0;
      else if (misalign)
         sync_err <= 1'b1;
      else if (err_clr)
         sync_err <= 1'b0;
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed and random stimulus against a queue-based frame model.
module tb_tdm_demux_1to4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic           in_sync = 1'b0;
   logic           err_clr = 1'b0;
   logic [4*W-1:0] out_frame;
   logic           out_valid;
   logic [1:0]     slot;
   logic           locked;
   logic           sync_err;

   int checks = 0;
   int errors = 0;

   // Reference model: samples collected so far in the current frame.
   int             q[$];
   bit             m_locked;
   bit             m_valid;
   bit             m_err;
   logic [4*W-1:0] m_frame;

   tdm_demux_1to4 #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_sync   (in_sync),
      .err_clr   (err_clr),
      .out_frame (out_frame),
      .out_valid (out_valid),
      .slot      (slot),
      .locked    (locked),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_locked = 0;
      m_valid  = 0;
      m_err    = 0;
      m_frame  = '0;
   endtask

   task automatic model_step(input bit v, input bit s,
                             input int d, input bit c);
      m_valid = 0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      if (c) m_err = 0;
`endif
      if (v) begin
         if (s) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            if (m_locked && q.size() != 0) m_err = 1;
`endif
            q.delete();
            q.push_back(d);
            m_locked = 1;
         end else if (m_locked) begin
            q.push_back(d);
         end
         if (q.size() == 4) begin
            m_frame = '0;
            for (int i = 0; i < 4; i++)
               m_frame[i*W +: W] = W'(q[i]);
            m_valid = 1;
            q.delete();
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".out_frame"}, 32'(out_frame), 32'(m_frame));
      chk({tag, ".slot"}, 32'(slot), 32'(q.size()));
      chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
      chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
   endtask

   // Inputs are driven 1 time unit after a rising edge; outputs sampled
   // 1 unit after the next edge.
   task automatic cyc(input string tag, input bit v, input bit s,
                      input int d, input bit c);
      in_valid = v;
      in_sync  = s;
      in_data  = W'(d);
      err_clr  = c;
      model_step(v, s, d, c);
      @(posedge clk);
      #1;
      in_valid = 0;
      in_sync  = 0;
      err_clr  = 0;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1;
      #1;
      model_clear();
      check_all(tag);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 0;

      // Basic frame 1,0,1,1
      cyc("f1.s0", 1, 1, 1, 0);
      cyc("f1.s1", 1, 0, 0, 0);
      cyc("f1.s2", 1, 0, 1, 0);
      cyc("f1.s3", 1, 0, 1, 0);
      chk("f1.word", 32'(out_frame), 32'h1101);
      cyc("f1.idle", 0, 0, 0, 0);

      // HUNT discard then 5,6,7,8
      do_reset("rst2");
      cyc("hunt.a", 1, 0, 9, 0);
      cyc("hunt.b", 1, 0, 10, 0);
      cyc("hunt.c", 1, 0, 11, 0);
      cyc("hunt.s0", 1, 1, 5, 0);
      cyc("hunt.s1", 1, 0, 6, 0);
      cyc("hunt.s2", 1, 0, 7, 0);
      cyc("hunt.s3", 1, 0, 8, 0);
      chk("hunt.word", 32'(out_frame), 32'h8765);

      // Three back-to-back frames, sync on first sample only
      for (int i = 0; i < 12; i++)
         cyc("stream", 1, i == 0, $urandom_range(0, 15), 0);

      // Misaligned sync at slot 2
      cyc("mis.s0", 1, 1, 3, 0);
      cyc("mis.s1", 1, 0, 4, 0);
      cyc("mis.sync", 1, 1, 12, 0);
      for (int i = 0; i < 3; i++)
         cyc("mis.after", 1, 0, 13 + i, 0);
      chk("mis.word", 32'(out_frame), 32'hFEDC);

      // err_clr colliding with a misaligned sync, then alone
      cyc("clr.s0", 1, 0, 2, 0);
      cyc("clr.both", 1, 1, 6, 1);
      cyc("clr.alone", 0, 0, 0, 1);

      // Reset between slot 1 and slot 2
      do_reset("rst3");
      cyc("mid.s0", 1, 1, 7, 0);
      cyc("mid.s1", 1, 0, 8, 0);
      do_reset("mid.rst");
      cyc("mid.ign0", 1, 0, 1, 0);
      cyc("mid.ign1", 1, 0, 2, 0);
      cyc("mid.ign2", 1, 0, 3, 0);
      cyc("mid.ign3", 1, 0, 4, 0);
      for (int i = 0; i < 4; i++)
         cyc("mid.frame", 1, i == 0, 10 + i, 0);

      // Random traffic
      for (int i = 0; i < 300; i++)
         cyc("rand", $urandom_range(0, 3) != 0,
             $urandom_range(0, 11) == 0,
             $urandom_range(0, 15),
             $urandom_range(0, 7) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Time-division demultiplexer that is the receiving end of the 4:1 select-driven mux path. It takes one W-bit sample per valid cycle from a serialised link whose samples are ordered by select value 0,1,2,3, and rebuilds the 4-channel parallel word. A frame-sync marker aligns the block to slot 0, and each complete frame is presented with a one-cycle valid strobe. It sits downstream of the mux/serialiser, feeding whatever logic consumes the original 4-input bus.

## Interface
- W, default 1, sample width per channel in bits (1..32)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_sync qualify this cycle
- in_data  input  W  serial sample
- in_sync  input  1  marks the sample as slot 0; meaningful only with in_valid
- err_clr  input  1  clears sticky sync_err
- out_frame  output  4*W  rebuilt word {ch3,ch2,ch1,ch0}; ch0 occupies bits W-1:0
- out_valid  output  1  one-cycle strobe, out_frame holds a new complete frame
- slot  output  2  slot index the next valid sample is written to (mirrors mux select)
- locked  output  1  high in LOCKED state
- sync_err  output  1  sticky misaligned-sync flag

## Operation
- Reset values: out_frame 0, out_valid 0, slot 0, locked 0, sync_err 0, channel registers 0, state HUNT.
- States: HUNT, LOCKED.
- HUNT: valid samples without in_sync are discarded. in_valid&in_sync: write in_data to ch0, slot<=1, go LOCKED.
- LOCKED, in_valid, no in_sync: write in_data to ch[slot], slot<=slot+1 (2-bit wrap 3->0).
- Writing slot 3 completes the frame: all four channel values (including the slot-3 sample) copied to out_frame, out_valid pulses.
- LOCKED, in_valid&in_sync with slot==0: aligned; treated as a normal slot-0 write.
- LOCKED, in_valid&in_sync with slot!=0: misaligned; partial frame discarded (no out_valid), sample written to ch0, slot<=1, state stays LOCKED; sync_err set (see Configuration).
- in_valid low: no state change; in_sync ignored.
- No backpressure: out_frame is held until the next frame completes, and the consumer must take it within 4 valid cycles.
- err_clr: sync_err<=0. A set event in the same cycle wins.
- W=1 reproduces the original 4-bit I vector on out_frame.

## Timing
- Latency: out_valid and the new out_frame appear on the clock edge that samples the slot-3 write, i.e. visible the cycle after the slot-3 sample is presented.
- Back-to-back frames: with in_valid held high, out_valid pulses every 4th cycle.
- The slot and locked outputs are registered and update on the same edge as the write.
- Reset asserted mid-frame: all registers clear immediately (asynchronously), state returns to HUNT, and no out_valid is produced for the partial frame.

## Configuration
- Macro TDM_DEMUX_SYNC_CHECK_EN.
- Defined: a misaligned sync sets sticky sync_err; err_clr behaves as above.
- Undefined: sync_err tied 0 and err_clr ignored. A misaligned sync still realigns and discards the partial frame.

## Structure
- Package tdm_demux_pkg holds NUM_CH=4, SLOT_W=2, and the state typedef (HUNT, LOCKED).
- One sub-module, tdm_slot_counter: a 2-bit wrapping counter with load-to-1 on sync, increment on valid, and a terminal-slot flag (slot==3 & valid).

## Test plan
- Reset, then W=1, in_valid high, sync on the first sample, data 1,0,1,1 -> one cycle later out_frame=4'b1101, out_valid high for exactly 1 cycle, locked=1.
- HUNT discard: 3 valid samples without sync, then a synced frame of values 5,6,7,8 (W=4) -> out_frame=16'h8765; no earlier out_valid.
- Continuous stream of 3 frames, sync only on the first -> out_valid at cycles 4, 8, 12 after the first sample; slot wraps 3->0.
- Misaligned sync at slot 2 -> no out_valid for the partial frame; sync_err=1 (macro defined) or 0 (undefined); the following 4 samples produce one correct frame.
- err_clr with a simultaneous misaligned sync -> sync_err stays 1; err_clr alone on the next cycle -> 0.
- rst pulsed between slot 1 and slot 2 -> all outputs 0 immediately, locked=0; unsynced samples ignored until the next sync.
